// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback sources.
// Define WB_FORWARD_EN to add write-to-read forwarding onto the two register-file read ports.
module wb_port_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       flush,
  output logic                       reg_wren,
  output logic [ADDR_W-1:0]          write_address,
  output logic [DATA_W-1:0]          write_data,
  output logic [2:0]                 grant_id,
`ifdef WB_FORWARD_EN
  input  logic [ADDR_W-1:0]          fwd_raddr1,
  input  logic [ADDR_W-1:0]          fwd_raddr2,
  input  logic [DATA_W-1:0]          fwd_rdata1_in,
  input  logic [DATA_W-1:0]          fwd_rdata2_in,
  output logic [DATA_W-1:0]          fwd_rdata1,
  output logic [DATA_W-1:0]          fwd_rdata2,
`endif
  output logic                       busy
);

  logic [2:0]        rr_ptr;
  logic [2:0]        win_idx;
  logic [2:0]        next_ptr;
  logic              found;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [3:0]        valid_cnt;

  // Wrapping search split into two passes (rr_ptr..top, then 0..rr_ptr-1) so every index is constant.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    if (!flush) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (3'(i) >= rr_ptr)) begin
          found   = 1'b1;
          win_idx = 3'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (3'(i) < rr_ptr)) begin
          found   = 1'b1;
          win_idx = 3'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    win_addr  = '0;
    win_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 3'(i)) begin
        req_ready[i] = found;
        win_addr     = req_addr[i*ADDR_W +: ADDR_W];
        win_data     = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    next_ptr = (win_idx == 3'(NUM_REQ - 1)) ? '0 : win_idx + 3'd1;
  end

  always_comb begin
    valid_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      valid_cnt = valid_cnt + {3'b000, req_valid[i]};
    end
    busy = (|req_valid) & ~flush & (valid_cnt > 4'd1);
  end

  // found is already masked by flush, so a flushed cycle neither writes nor moves the pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      reg_wren      <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      grant_id      <= '0;
    end else if (found) begin
      rr_ptr        <= next_ptr;
      reg_wren      <= |win_addr;
      write_address <= win_addr;
      write_data    <= win_data;
      grant_id      <= win_idx;
    end else begin
      reg_wren      <= 1'b0;
    end
  end

`ifdef WB_FORWARD_EN
  always_comb begin
    fwd_rdata1 = (reg_wren && (write_address == fwd_raddr1) && (fwd_raddr1 != '0))
                 ? write_data : fwd_rdata1_in;
    fwd_rdata2 = (reg_wren && (write_address == fwd_raddr2) && (fwd_raddr2 != '0))
                 ? write_data : fwd_rdata2_in;
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter: stimulus pushes expected output-stage values,
// a monitor one clock later pops and compares them.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        flush;
  logic        reg_wren;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [2:0]  grant_id;
  logic        busy;
`ifdef WB_FORWARD_EN
  logic [4:0]  fwd_raddr1, fwd_raddr2;
  logic [31:0] fwd_rdata1_in, fwd_rdata2_in, fwd_rdata1, fwd_rdata2;
`endif

  wb_port_arbiter #(
    .NUM_REQ (3),
    .DATA_W  (32),
    .ADDR_W  (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .flush         (flush),
    .reg_wren      (reg_wren),
    .write_address (write_address),
    .write_data    (write_data),
    .grant_id      (grant_id),
`ifdef WB_FORWARD_EN
    .fwd_raddr1    (fwd_raddr1),
    .fwd_raddr2    (fwd_raddr2),
    .fwd_rdata1_in (fwd_rdata1_in),
    .fwd_rdata2_in (fwd_rdata2_in),
    .fwd_rdata1    (fwd_rdata1),
    .fwd_rdata2    (fwd_rdata2),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  gid;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic [14:0] pack_addr(input logic [4:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [95:0] pack_data(input logic [31:0] d0, d1, d2);
    return {d2, d1, d0};
  endfunction

  // Drive one cycle at negedge, check combinational ready/busy, queue expected registered result.
  task automatic drive(input string nm, input logic [2:0] v, input logic f,
                       input logic [2:0] er, input logic eb,
                       input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                       input logic [2:0] eg);
    exp_t e;
    @(negedge clk);
    req_valid = v;
    flush     = f;
    #1;
    chk({nm, ".ready"}, 32'(req_ready), 32'(er));
    chk({nm, ".busy"},  32'(busy),      32'(eb));
    e.wren = ew; e.addr = ea; e.data = ed; e.gid = eg; e.nm = nm;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".wren"}, 32'(reg_wren),      32'(e.wren));
      chk({e.nm, ".addr"}, 32'(write_address), 32'(e.addr));
      chk({e.nm, ".data"}, write_data,         e.data);
      chk({e.nm, ".gid"},  32'(grant_id),      32'(e.gid));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    flush     = 1'b0;
    req_addr  = pack_addr(5'd5, 5'd6, 5'd7);
    req_data  = pack_data(32'hA, 32'hB, 32'hC);
`ifdef WB_FORWARD_EN
    fwd_raddr1 = '0; fwd_raddr2 = '0; fwd_rdata1_in = '0; fwd_rdata2_in = '0;
`endif
    #12;
    chk("rst.wren", 32'(reg_wren),      32'd0);
    chk("rst.addr", 32'(write_address), 32'd0);
    chk("rst.data", write_data,         32'd0);
    chk("rst.gid",  32'(grant_id),      32'd0);
    chk("rst.busy", 32'(busy),          32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fairness rotation with all sources valid
    drive("rr0",  3'b111, 1'b0, 3'b001, 1'b1, 1'b1, 5'd5, 32'hA, 3'd0);
    drive("rr1",  3'b111, 1'b0, 3'b010, 1'b1, 1'b1, 5'd6, 32'hB, 3'd1);
    drive("rr2",  3'b111, 1'b0, 3'b100, 1'b1, 1'b1, 5'd7, 32'hC, 3'd2);
    drive("rr3",  3'b111, 1'b0, 3'b001, 1'b1, 1'b1, 5'd5, 32'hA, 3'd0);
    drive("idle", 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 5'd5, 32'hA, 3'd0);

    // Write to x0 consumed without write enable; pointer moves to 2
    req_addr = pack_addr(5'd5, 5'd0, 5'd7);
    req_data = pack_data(32'hA, 32'hDEAD, 32'h1234);
    drive("x0",   3'b010, 1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 32'hDEAD, 3'd1);
    drive("ptr2", 3'b101, 1'b0, 3'b100, 1'b1, 1'b1, 5'd7, 32'h1234, 3'd2);
    drive("solo", 3'b001, 1'b0, 3'b001, 1'b0, 1'b1, 5'd5, 32'hA, 3'd0);

    // rr_ptr=1 with sources 0 and 2: source 2 first, then 0
    drive("skip2", 3'b101, 1'b0, 3'b100, 1'b1, 1'b1, 5'd7, 32'h1234, 3'd2);
    drive("skip0", 3'b101, 1'b0, 3'b001, 1'b1, 1'b1, 5'd5, 32'hA, 3'd0);

    // Flush masks everything and leaves the pointer at 1
    req_addr = pack_addr(5'd5, 5'd6, 5'd7);
    req_data = pack_data(32'hA, 32'hB, 32'h1234);
    drive("flush", 3'b111, 1'b1, 3'b000, 1'b0, 1'b0, 5'd5, 32'hA, 3'd0);
    drive("aftfl", 3'b111, 1'b0, 3'b010, 1'b1, 1'b1, 5'd6, 32'hB, 3'd1);

    // Asynchronous reset while a write is on the output
    @(posedge clk);
    #2;
    chk("prerst.wren", 32'(reg_wren), 32'd1);
    req_valid = '0;
    reset     = 1'b1;
    #1;
    chk("arst.wren", 32'(reg_wren),      32'd0);
    chk("arst.addr", 32'(write_address), 32'd0);
    chk("arst.data", write_data,         32'd0);
    chk("arst.gid",  32'(grant_id),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive("postrst", 3'b111, 1'b0, 3'b001, 1'b1, 1'b1, 5'd5, 32'hA, 3'd0);

`ifdef WB_FORWARD_EN
    req_addr = pack_addr(5'd10, 5'd6, 5'd7);
    req_data = pack_data(32'h55, 32'hB, 32'h1234);
    drive("fwdwr", 3'b001, 1'b0, 3'b001, 1'b0, 1'b1, 5'd10, 32'h55, 3'd0);
    @(negedge clk);
    req_valid     = '0;
    fwd_raddr1    = 5'd10;
    fwd_raddr2    = 5'd0;
    fwd_rdata1_in = 32'h111;
    fwd_rdata2_in = 32'h222;
    #1;
    chk("fwd1", fwd_rdata1, 32'h55);
    chk("fwd2", fwd_rdata2, 32'h222);
    fwd_raddr1 = 5'd11;
    #1;
    chk("fwd1miss", fwd_rdata1, 32'h111);
`endif

    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
